// File: rtl/data_ram_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : data_ram_responder_if
// Description : CPU data-RAM port plus the valid/ready dump port, bundled.
//               The master side is the CPU/host; the slave side is the RAM.
// Revision    : 1.0 - initial release
// ============================================================================
interface data_ram_responder_if #(
    parameter int nBit   = 16,
    parameter int ADDR_W = 6
);
    logic [ADDR_W-1:0] address_to_ram;
    logic [nBit-1:0]   data_to_ram;
    logic              write_enable_to_ram;
    logic              read_enable_to_ram;
    logic              enable_ram_read;
    logic [nBit-1:0]   data_from_ram;
    logic              dump_valid;
    logic              dump_ready;
    logic [ADDR_W-1:0] dump_addr;
    logic [nBit-1:0]   dump_data;
    logic              dump_done;
    logic [6:0]        write_count;

    modport master (
        output address_to_ram, data_to_ram, write_enable_to_ram,
               read_enable_to_ram, enable_ram_read, dump_ready,
        input  data_from_ram, dump_valid, dump_addr, dump_data,
               dump_done, write_count
    );

    modport slave (
        input  address_to_ram, data_to_ram, write_enable_to_ram,
               read_enable_to_ram, enable_ram_read, dump_ready,
        output data_from_ram, dump_valid, dump_addr, dump_data,
               dump_done, write_count
    );
endinterface
`default_nettype wire

// File: rtl/data_ram_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_ram_responder
// Description : DEPTH x nBit data RAM serving CPU loads (zero latency) and
//               stores; on the CPU done flag it freezes and streams words
//               DUMP_FIRST..DUMP_LAST out over a valid/ready dump port.
// Revision    : 1.0 - initial release
// ============================================================================
module data_ram_responder #(
    parameter int nBit       = 16,
    parameter int ADDR_W     = 6,
    parameter int DUMP_FIRST = 0,
    parameter int DUMP_LAST  = 63
) (
    input  wire logic           clk,
    input  wire logic           reset,
    data_ram_responder_if.slave bus
);
    localparam int                DEPTH        = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] c_DUMP_FIRST = ADDR_W'(DUMP_FIRST);
    localparam logic [ADDR_W-1:0] c_DUMP_LAST  = ADDR_W'(DUMP_LAST);
    localparam logic [6:0]        c_CNT_MAX    = 7'd127;

    typedef enum logic [1:0] {
        S_SERVE = 2'd0,
        S_DUMP  = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] w_ptr_nxt;
    logic [nBit-1:0]   r_mem [DEPTH];
    logic [6:0]        r_write_count;
    logic              w_store;
    logic              w_dump_valid;
    logic              w_dump_done;

    // State and dump pointer registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_SERVE;
            r_ptr   <= c_DUMP_FIRST;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // Next-state, pointer advance and store qualification; stores only land in SERVE
    always_comb begin
        w_state_nxt  = r_state;
        w_ptr_nxt    = r_ptr;
        w_store      = 1'b0;
        w_dump_valid = 1'b0;
        w_dump_done  = 1'b0;
        case (r_state)
            S_SERVE: begin
                w_store = bus.write_enable_to_ram;
                if (bus.enable_ram_read) begin
                    w_state_nxt = S_DUMP;
                    w_ptr_nxt   = c_DUMP_FIRST;
                end
            end
            S_DUMP: begin
                w_dump_valid = 1'b1;
                if (bus.dump_ready) begin
                    if (r_ptr == c_DUMP_LAST) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_ptr_nxt = r_ptr + 1'b1;
                    end
                end
            end
            S_DONE: begin
                w_dump_done = 1'b1;
            end
            default: begin
                w_state_nxt = S_SERVE;
            end
        endcase
    end

    // Memory array: cleared on reset, written by qualified CPU stores
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_store) begin
            r_mem[bus.address_to_ram] <= bus.data_to_ram;
        end
    end

    // Saturating count of accepted stores
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_write_count <= '0;
        end else if (w_store && (r_write_count != c_CNT_MAX)) begin
            r_write_count <= r_write_count + 7'd1;
        end
    end

    // Combinational read paths for the CPU load port and the dump port
    always_comb begin
        bus.data_from_ram = bus.read_enable_to_ram ? r_mem[bus.address_to_ram] : '0;
        bus.dump_valid    = w_dump_valid;
        bus.dump_done     = w_dump_done;
        bus.dump_addr     = r_ptr;
        bus.dump_data     = r_mem[r_ptr];
        bus.write_count   = r_write_count;
    end
endmodule
`default_nettype wire

// File: tb/tb_data_ram_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_ram_responder
// Description : Randomized self-checking bench for data_ram_responder with a
//               behavioural RAM/dump reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_ram_responder;
    localparam int NB    = 16;
    localparam int AW    = 6;
    localparam int DEPTH = 64;
    localparam int FIRST = 0;
    localparam int LAST  = 63;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    data_ram_responder_if #(.nBit(NB), .ADDR_W(AW)) bus ();

    data_ram_responder #(
        .nBit(NB), .ADDR_W(AW), .DUMP_FIRST(FIRST), .DUMP_LAST(LAST)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Reference model: plain array, counter, phase (0 serve, 1 dumping, 2 done)
    int unsigned m_mem [DEPTH];
    int          m_cnt;
    int          m_phase;
    int          m_ptr;
    int          dut_beats[$];
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        foreach (m_mem[i]) m_mem[i] = 0;
        m_cnt   = 0;
        m_phase = 0;
        m_ptr   = FIRST;
    endtask

    task automatic model_edge();
        if (m_phase == 0) begin
            if (bus.write_enable_to_ram) begin
                m_mem[bus.address_to_ram] = bus.data_to_ram;
                if (m_cnt < 127) m_cnt++;
            end
            if (bus.enable_ram_read) begin
                m_phase = 1;
                m_ptr   = FIRST;
            end
        end else if (m_phase == 1 && bus.dump_ready) begin
            if (m_ptr == LAST) m_phase = 2;
            else m_ptr++;
        end
    endtask

    task automatic check_all();
        chk("rdata", bus.data_from_ram,
            bus.read_enable_to_ram ? m_mem[bus.address_to_ram] : 0);
        chk("dvalid", bus.dump_valid, m_phase == 1);
        chk("ddone", bus.dump_done, m_phase == 2);
        chk("wcnt", bus.write_count, m_cnt);
        if (m_phase == 1) begin
            chk("daddr", bus.dump_addr, m_ptr);
            chk("ddata", bus.dump_data, m_mem[m_ptr]);
        end
        if (bus.dump_valid && bus.dump_ready) dut_beats.push_back(int'(bus.dump_addr));
    endtask

    // One clock: check settled outputs, advance model at the edge, step past it
    task automatic cyc();
        #1;
        check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        bus.address_to_ram      = '0;
        bus.data_to_ram         = '0;
        bus.write_enable_to_ram = 1'b0;
        bus.read_enable_to_ram  = 1'b0;
        bus.enable_ram_read     = 1'b0;
        bus.dump_ready          = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        #1;
    endtask

    task automatic store(input int a, input int d);
        bus.write_enable_to_ram = 1'b1;
        bus.address_to_ram      = AW'(a);
        bus.data_to_ram         = NB'(d);
        cyc();
        bus.write_enable_to_ram = 1'b0;
    endtask

    initial begin
        int       cycles;
        int       prev_addr;
        int       prev_data;
        logic     prev_stall;
        int       pat;

        // Reset state
        idle_inputs();
        reset = 1'b1;
        model_reset();
        #3;
        chk("rst_valid", bus.dump_valid, 0);
        chk("rst_done", bus.dump_done, 0);
        chk("rst_addr", bus.dump_addr, FIRST);
        chk("rst_data", bus.dump_data, 0);
        chk("rst_wcnt", bus.write_count, 0);
        do_reset();

        // Basic store/load, read gating
        store(5, 16'hBEEF);
        bus.read_enable_to_ram = 1'b1;
        bus.address_to_ram     = 6'd5;
        #1 chk("t1_rd5", bus.data_from_ram, 16'hBEEF);
        cyc();
        bus.address_to_ram = 6'd6;
        #1 chk("t1_rd6", bus.data_from_ram, 16'h0000);
        cyc();
        bus.read_enable_to_ram = 1'b0;
        bus.address_to_ram     = 6'd5;
        #1 chk("t1_rden0", bus.data_from_ram, 16'h0000);
        chk("t1_wcnt", bus.write_count, 1);
        cyc();

        // Read during write returns the old word, new word after the edge
        bus.read_enable_to_ram  = 1'b1;
        bus.write_enable_to_ram = 1'b1;
        bus.address_to_ram      = 6'd9;
        bus.data_to_ram         = 16'h1111;
        #1 chk("t2_old", bus.data_from_ram, 16'h0000);
        cyc();
        bus.write_enable_to_ram = 1'b0;
        #1 chk("t2_new", bus.data_from_ram, 16'h1111);
        cyc();

        // Random serve traffic
        for (int i = 0; i < 150; i++) begin
            bus.write_enable_to_ram = 1'($urandom_range(0, 1));
            bus.read_enable_to_ram  = 1'($urandom_range(0, 1));
            bus.address_to_ram      = AW'($urandom);
            bus.data_to_ram         = NB'($urandom);
            cyc();
        end
        idle_inputs();

        // Full dump with ready held high, CPU stores to @2 during it are ignored
        store(63, 16'hA5A5);
        bus.enable_ram_read = 1'b1;
        bus.dump_ready      = 1'b1;
        cyc();
        bus.enable_ram_read = 1'b0;
        dut_beats.delete();
        for (int k = 0; k <= LAST; k++) begin
            chk("t3_addr", bus.dump_addr, k);
            if (k == LAST) chk("t3_last", bus.dump_data, 16'hA5A5);
            bus.write_enable_to_ram = 1'($urandom_range(0, 1));
            bus.address_to_ram      = 6'd2;
            bus.data_to_ram         = 16'h1234;
            bus.read_enable_to_ram  = 1'b1;
            cyc();
        end
        chk("t3_beats", dut_beats.size(), 64);
        chk("t3_done", bus.dump_done, 1);
        chk("t3_valid", bus.dump_valid, 0);

        // Stores in DONE are ignored
        for (int i = 0; i < 4; i++) store(2, 16'h1234);
        bus.read_enable_to_ram = 1'b1;
        bus.address_to_ram     = 6'd2;
        #1 chk("t5_mem2", bus.data_from_ram, m_mem[2]);
        cyc();

        // Stalled dump with ready pattern 1,0,0 mixed with random
        do_reset();
        for (int i = 0; i < 40; i++) store(int'($urandom_range(0, 63)), int'($urandom));
        bus.enable_ram_read = 1'b1;
        cyc();
        bus.enable_ram_read = 1'b0;
        dut_beats.delete();
        cycles     = 0;
        pat        = 0;
        prev_stall = 1'b0;
        prev_addr  = 0;
        prev_data  = 0;
        while (!bus.dump_done && cycles < 1000) begin
            if (prev_stall) begin
                chk("t4_hold_addr", bus.dump_addr, prev_addr);
                chk("t4_hold_data", bus.dump_data, prev_data);
            end
            bus.dump_ready = (cycles < 90) ? (pat == 0) : 1'($urandom_range(0, 1));
            pat = (pat == 2) ? 0 : pat + 1;
            prev_stall = bus.dump_valid && !bus.dump_ready;
            prev_addr  = int'(bus.dump_addr);
            prev_data  = int'(bus.dump_data);
            cyc();
            cycles++;
        end
        if (cycles >= 1000) chk("t4_timeout", 1, 0);
        chk("t4_beats", dut_beats.size(), 64);
        foreach (dut_beats[i]) begin
            if (dut_beats[i] != i) chk("t4_order", dut_beats[i], i);
        end
        if (dut_beats.size() > 0) chk("t4_last", dut_beats[dut_beats.size()-1], LAST);

        // Saturation, then reset in the middle of a dump
        do_reset();
        for (int i = 0; i < 130; i++) store(int'($urandom_range(0, 63)), int'($urandom_range(1, 65535)));
        chk("t6_sat", bus.write_count, 127);
        bus.enable_ram_read = 1'b1;
        bus.dump_ready      = 1'b1;
        cyc();
        bus.enable_ram_read = 1'b0;
        cycles = 0;
        while (bus.dump_addr != 6'd20 && cycles < 200) begin
            cyc();
            cycles++;
        end
        if (cycles >= 200) chk("t6_timeout", 1, 0);
        chk("t6_pre_valid", bus.dump_valid, 1);
        reset = 1'b1;
        #1;
        chk("t6_rst_valid", bus.dump_valid, 0);
        chk("t6_rst_addr", bus.dump_addr, FIRST);
        chk("t6_rst_data", bus.dump_data, 0);
        chk("t6_rst_wcnt", bus.write_count, 0);
        model_reset();
        idle_inputs();
        #2 reset = 1'b0;
        bus.read_enable_to_ram = 1'b1;
        for (int a = 0; a < DEPTH; a++) begin
            bus.address_to_ram = AW'(a);
            #1 if (bus.data_from_ram !== '0) chk("t6_clear", bus.data_from_ram, 0);
            cyc();
        end
        store(7, 16'h0F0F);
        chk("t6_serve_wcnt", bus.write_count, 1);
        bus.address_to_ram = 6'd7;
        #1 chk("t6_serve_rd", bus.data_from_ram, 16'h0F0F);
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
